// File: rtl/lfsr_pkg.sv
// Shared definitions for the XNOR LFSR pattern generator and its checker.
package lfsr_pkg;

  localparam int LFSR_W      = 49;
  localparam int LFSR_TAP_HI = 49;
  localparam int LFSR_TAP_LO = 40;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEED,
    S_CHECK,
    S_DONE
  } state_t;

  // Advance the register by one step. The MSB falls off the top and the XNOR
  // of the two taps enters at the bottom. Tap numbers count from 1, so they
  // map to bit indices one lower.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x);
    return {x[LFSR_W-2:0], ~(x[LFSR_TAP_HI-1] ^ x[LFSR_TAP_LO-1])};
  endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker. It seeds itself from the first valid word, then
// predicts every later word and counts mismatches until the stop code arrives.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int NUM_BITS   = 49,
  parameter int ERR_W      = 16,
  parameter int CNT_W      = 32,
  parameter int RESYNC_THR = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_vld,
  input  logic [NUM_BITS-1:0] i_data,
  input  logic [NUM_BITS-1:0] i_stop_code,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_pass,
  output logic                o_err,
  output logic [ERR_W-1:0]    o_err_cnt,
  output logic [CNT_W-1:0]    o_word_cnt,
  output logic [NUM_BITS-1:0] o_first_err_data,
  output logic                o_lockup
);

  // The run counter needs to hold RESYNC_THR and still saturate when reseeding
  // is disabled, so it is sized one value above the threshold.
  localparam int                MISS_W   = $clog2(RESYNC_THR + 2);
  localparam logic [MISS_W-1:0] MISS_THR = MISS_W'(RESYNC_THR);
  localparam logic [MISS_W-1:0] MISS_ONE = {{(MISS_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0]  ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              state;
  logic [NUM_BITS-1:0] expected;
  logic [MISS_W-1:0]   miss_run;

  logic                mismatch;
  logic                is_stop;
  logic                all_ones;
  logic                resync_hit;
  logic [ERR_W-1:0]    err_cnt_inc;
  logic [CNT_W-1:0]    word_cnt_inc;
  logic [MISS_W-1:0]   miss_run_inc;

  // Compare the incoming word and form the saturating counter increments.
  always_comb begin
    mismatch     = (i_data != expected);
    is_stop      = (i_data == i_stop_code);
    all_ones     = &i_data;
    err_cnt_inc  = (&o_err_cnt)  ? o_err_cnt  : o_err_cnt + ERR_ONE;
    word_cnt_inc = (&o_word_cnt) ? o_word_cnt : o_word_cnt + CNT_ONE;
    miss_run_inc = (&miss_run)   ? miss_run   : miss_run + MISS_ONE;
    resync_hit   = (RESYNC_THR != 0) && (miss_run_inc >= MISS_THR);
  end

  // Checker FSM with registered status outputs. Start beats a coincident
  // valid word; stop beats a resync on the same word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= S_IDLE;
      expected         <= '0;
      miss_run         <= '0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_pass           <= 1'b0;
      o_err            <= 1'b0;
      o_err_cnt        <= '0;
      o_word_cnt       <= '0;
      o_first_err_data <= '0;
      o_lockup         <= 1'b0;
    end else begin
      o_err <= 1'b0;
      if (i_start) begin
        state            <= S_SEED;
        miss_run         <= '0;
        o_busy           <= 1'b1;
        o_done           <= 1'b0;
        o_pass           <= 1'b0;
        o_err_cnt        <= '0;
        o_word_cnt       <= '0;
        o_first_err_data <= '0;
        o_lockup         <= 1'b0;
      end else begin
        case (state)
          S_SEED: begin
            if (i_vld) begin
              if (all_ones) begin
                o_lockup <= 1'b1;
              end else begin
                expected <= lfsr_next(i_data);
                miss_run <= '0;
                if (is_stop) begin
                  state  <= S_DONE;
                  o_busy <= 1'b0;
                  o_done <= 1'b1;
                  o_pass <= (o_err_cnt == '0);
                end else begin
                  state <= S_CHECK;
                end
              end
            end
          end
          S_CHECK: begin
            if (i_vld) begin
              expected   <= lfsr_next(expected);
              o_word_cnt <= word_cnt_inc;
              if (mismatch) begin
                o_err     <= 1'b1;
                o_err_cnt <= err_cnt_inc;
                miss_run  <= miss_run_inc;
                if (o_err_cnt == '0) begin
                  o_first_err_data <= i_data;
                end
              end else begin
                miss_run <= '0;
              end
              if (is_stop) begin
                state  <= S_DONE;
                o_busy <= 1'b0;
                o_done <= 1'b1;
                o_pass <= !mismatch && (o_err_cnt == '0);
              end else if (mismatch && resync_hit) begin
                state <= S_SEED;
              end
            end
          end
          S_IDLE, S_DONE: begin
          end
          default: begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed testbench for lfsr_checker: a vector table for the single-pass
// scenarios plus hand-written sequences for resync, lockup, saturation and reset.
module tb_lfsr_checker;

  localparam logic [48:0] ALL_ONES = 49'h1_FFFF_FFFF_FFFF;
  localparam logic [48:0] STOP_F   = 49'hF;

  logic        clk;
  logic        rst;
  logic        start;
  logic        vld;
  logic [48:0] data;
  logic [48:0] stop;

  logic        busy, done, pass, err, lockup;
  logic [15:0] err_cnt;
  logic [31:0] word_cnt;
  logic [48:0] first_err;

  logic        busy2, done2, pass2, err2, lockup2;
  logic [3:0]  err_cnt2;
  logic [31:0] word_cnt2;
  logic [48:0] first_err2;

  int vectors;
  int miscompares;

  typedef struct {
    string       name;
    logic        start;
    logic        vld;
    logic [48:0] data;
    logic [48:0] stop;
    logic        busy;
    logic        done;
    logic        pass;
    logic        err;
    logic [15:0] err_cnt;
    logic [31:0] word_cnt;
    logic [48:0] first_err;
  } vec_t;

  vec_t vecs[$];

  lfsr_checker #(.NUM_BITS(49), .ERR_W(16), .CNT_W(32), .RESYNC_THR(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_vld(vld), .i_data(data),
    .i_stop_code(stop), .o_busy(busy), .o_done(done), .o_pass(pass), .o_err(err),
    .o_err_cnt(err_cnt), .o_word_cnt(word_cnt), .o_first_err_data(first_err),
    .o_lockup(lockup)
  );

  lfsr_checker #(.NUM_BITS(49), .ERR_W(4), .CNT_W(32), .RESYNC_THR(0)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_vld(vld), .i_data(data),
    .i_stop_code(stop), .o_busy(busy2), .o_done(done2), .o_pass(pass2), .o_err(err2),
    .o_err_cnt(err_cnt2), .o_word_cnt(word_cnt2), .o_first_err_data(first_err2),
    .o_lockup(lockup2)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(string n, logic s, logic v, logic [48:0] d, logic [48:0] st,
                              logic b, logic dn, logic p, logic e, logic [15:0] ec,
                              logic [31:0] wc, logic [48:0] fe);
    vec_t r;
    r.name = n; r.start = s; r.vld = v; r.data = d; r.stop = st;
    r.busy = b; r.done = dn; r.pass = p; r.err = e;
    r.err_cnt = ec; r.word_cnt = wc; r.first_err = fe;
    return r;
  endfunction

  function automatic logic [63:0] pack(logic b, logic dn, logic p, logic e, logic l,
                                       logic [15:0] ec, logic [31:0] wc);
    return {11'd0, b, dn, p, e, l, ec, wc};
  endfunction

  function automatic logic [63:0] actual();
    return pack(busy, done, pass, err, lockup, err_cnt, word_cnt);
  endfunction

  // Drive one cycle of inputs and let it be sampled by the next rising edge.
  task automatic applyStimulus(input logic r, input logic s, input logic v,
                               input logic [48:0] d, input logic [48:0] st);
    rst = r; start = s; vld = v; data = d; stop = st;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; start = 1'b0; vld = 1'b0; data = '0; stop = '0;

    // Clean stream 1,3,7,F with stop F.
    vecs.push_back(mk("c_start", 1, 0, 49'h0, STOP_F, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("c_seed",  0, 1, 49'h1, STOP_F, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("c_w3",    0, 1, 49'h3, STOP_F, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("c_w7",    0, 1, 49'h7, STOP_F, 1, 0, 0, 0, 0, 2, 0));
    vecs.push_back(mk("c_stop",  0, 1, 49'hF, STOP_F, 0, 1, 1, 0, 0, 3, 0));
    vecs.push_back(mk("c_hold",  0, 0, 49'h0, STOP_F, 0, 1, 1, 0, 0, 3, 0));
    // Single corrupted word; expected keeps advancing so F still matches.
    vecs.push_back(mk("e_start", 1, 0, 49'h0, STOP_F, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("e_seed",  0, 1, 49'h1, STOP_F, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("e_w3",    0, 1, 49'h3, STOP_F, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("e_w5",    0, 1, 49'h5, STOP_F, 1, 0, 0, 1, 1, 2, 49'h5));
    vecs.push_back(mk("e_stop",  0, 1, 49'hF, STOP_F, 0, 1, 0, 0, 1, 3, 49'h5));
    // Idle gaps between valid words do not advance the prediction.
    vecs.push_back(mk("g_start", 1, 0, 49'h0, STOP_F, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("g_seed",  0, 1, 49'h1, STOP_F, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("g_w3",    0, 1, 49'h3, STOP_F, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("g_gap0",  0, 0, 49'h5, STOP_F, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("g_gap1",  0, 0, 49'h5, STOP_F, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("g_gap2",  0, 0, 49'h5, STOP_F, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("g_w7",    0, 1, 49'h7, STOP_F, 1, 0, 0, 0, 0, 2, 0));
    vecs.push_back(mk("g_stop",  0, 1, 49'hF, STOP_F, 0, 1, 1, 0, 0, 3, 0));
    // Start and valid together: the word is dropped, 3 becomes the seed.
    vecs.push_back(mk("s_start", 1, 0, 49'h0, STOP_F, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("s_both",  1, 1, 49'h1, STOP_F, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("s_seed3", 0, 1, 49'h3, STOP_F, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("s_w7",    0, 1, 49'h7, STOP_F, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("s_stop",  0, 1, 49'hF, STOP_F, 0, 1, 1, 0, 0, 2, 0));
    // Seeds with both taps set exercise the feedback positions.
    vecs.push_back(mk("t_start", 1, 0, 49'h0,               49'h200_0000_0003, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t_seed",  0, 1, 49'h1_0080_0000_0000, 49'h200_0000_0003, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t_w1",    0, 1, 49'h100_0000_0001,   49'h200_0000_0003, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk("t_stop",  0, 1, 49'h200_0000_0003,   49'h200_0000_0003, 0, 1, 1, 0, 0, 2, 0));
    vecs.push_back(mk("t2_start", 1, 0, 49'h0,               49'h0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t2_seed",  0, 1, 49'h1_0000_0000_0000, 49'h0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("t2_stop",  0, 1, 49'h0,               49'h0, 0, 1, 1, 0, 0, 1, 0));
    // Stop code arriving as the seed ends the check with nothing compared.
    vecs.push_back(mk("z_start", 1, 0, 49'h0, STOP_F, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("z_seed",  0, 1, 49'hF, STOP_F, 0, 1, 1, 0, 0, 0, 0));

    // Reset state of both instances.
    applyStimulus(1, 0, 0, 49'h0, 49'h0);
    applyStimulus(1, 1, 1, 49'h1, 49'h1);
    checkOutput("rst_outs", actual(), pack(0, 0, 0, 0, 0, 0, 0));
    checkOutput("rst_first_err", {15'd0, first_err}, 64'd0);
    checkOutput("rst_sat_outs", {21'd0, busy2, done2, pass2, err2, lockup2, err_cnt2, word_cnt2}, 64'd0);

    // Table-driven single-pass scenarios.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(0, vecs[i].start, vecs[i].vld, vecs[i].data, vecs[i].stop);
      checkOutput(vecs[i].name, actual(),
                  pack(vecs[i].busy, vecs[i].done, vecs[i].pass, vecs[i].err, 1'b0,
                       vecs[i].err_cnt, vecs[i].word_cnt));
      checkOutput({vecs[i].name, "_fe"}, {15'd0, first_err}, {15'd0, vecs[i].first_err});
    end

    // Four consecutive mismatches force a reseed; the clean restart then matches.
    begin
      logic [48:0] junk [4];
      junk[0] = 49'h100; junk[1] = 49'h200; junk[2] = 49'h400; junk[3] = 49'h800;
      applyStimulus(0, 1, 0, 49'h0, STOP_F);
      applyStimulus(0, 0, 1, 49'h1, STOP_F);
      for (int i = 0; i < 4; i++) begin
        applyStimulus(0, 0, 1, junk[i], STOP_F);
        checkOutput($sformatf("rs_junk%0d", i), actual(),
                    pack(1, 0, 0, 1, 0, 16'(i + 1), 32'(i + 1)));
      end
      applyStimulus(0, 0, 1, 49'h1, STOP_F);
      checkOutput("rs_reseed", actual(), pack(1, 0, 0, 0, 0, 4, 4));
      applyStimulus(0, 0, 1, 49'h3, STOP_F);
      checkOutput("rs_w3", actual(), pack(1, 0, 0, 0, 0, 4, 5));
      applyStimulus(0, 0, 1, 49'h7, STOP_F);
      checkOutput("rs_w7", actual(), pack(1, 0, 0, 0, 0, 4, 6));
      applyStimulus(0, 0, 1, 49'hF, STOP_F);
      checkOutput("rs_stop", actual(), pack(0, 1, 0, 0, 0, 4, 7));
      checkOutput("rs_first_err", {15'd0, first_err}, 64'h100);

      // Fourth mismatch is also the stop code: stop wins over resync.
      applyStimulus(0, 1, 0, 49'h0, 49'h800);
      applyStimulus(0, 0, 1, 49'h1, 49'h800);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, junk[i], 49'h800);
      applyStimulus(0, 0, 1, 49'h800, 49'h800);
      checkOutput("rs_stop_wins", actual(), pack(0, 1, 0, 1, 0, 4, 4));
    end

    // All-ones seed is the lockup word: flag it and keep waiting for a seed.
    applyStimulus(0, 1, 0, 49'h0, STOP_F);
    applyStimulus(0, 0, 1, ALL_ONES, STOP_F);
    checkOutput("lk_flag", actual(), pack(1, 0, 0, 0, 1, 0, 0));
    applyStimulus(0, 0, 1, 49'h1, STOP_F);
    checkOutput("lk_seed", actual(), pack(1, 0, 0, 0, 1, 0, 0));
    applyStimulus(0, 0, 1, 49'h3, STOP_F);
    checkOutput("lk_w3", actual(), pack(1, 0, 0, 0, 1, 0, 1));
    applyStimulus(0, 1, 0, 49'h0, STOP_F);
    checkOutput("lk_cleared", actual(), pack(1, 0, 0, 0, 0, 0, 0));

    // 4-bit error counter with reseeding off: 20 mismatches saturate at 15.
    applyStimulus(0, 0, 1, 49'h1, STOP_F);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 1, 49'h0, STOP_F);
      checkOutput($sformatf("sat_err%0d", i), {59'd0, err2, err_cnt2},
                  {59'd0, 1'b1, (i < 15) ? 4'(i + 1) : 4'd15});
    end
    checkOutput("sat_words", {32'd0, word_cnt2}, 64'd20);

    // Reset mid-check clears everything and the checker stays idle until start.
    applyStimulus(0, 1, 0, 49'h0, STOP_F);
    applyStimulus(0, 0, 1, 49'h1, STOP_F);
    applyStimulus(0, 0, 1, 49'h5, STOP_F);
    checkOutput("mr_before", actual(), pack(1, 0, 0, 1, 0, 1, 1));
    applyStimulus(1, 0, 1, 49'h7, STOP_F);
    checkOutput("mr_reset", actual(), pack(0, 0, 0, 0, 0, 0, 0));
    checkOutput("mr_first_err", {15'd0, first_err}, 64'd0);
    applyStimulus(0, 0, 1, 49'h1, STOP_F);
    applyStimulus(0, 0, 1, 49'h3, STOP_F);
    checkOutput("mr_idle", actual(), pack(0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 1, 0, 49'h0, STOP_F);
    applyStimulus(0, 0, 1, 49'h1, STOP_F);
    applyStimulus(0, 0, 1, 49'h3, STOP_F);
    checkOutput("mr_restart", actual(), pack(1, 0, 0, 0, 0, 0, 1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
Receive-side companion to the team's XNOR LFSR pattern generator. It consumes a valid-qualified LFSR word stream returned from the systolic array test path. It self-seeds from the first received word, predicts each following word with a local LFSR, and counts mismatches. It also detects the stop code and reports pass/fail status for the test controller.

Parameters:
NUM_BITS, 49, LFSR width; the feedback taps are fixed at bit positions 49 and 40 (1-indexed).
ERR_W, 16, width of the saturating error counter.
CNT_W, 32, width of the saturating checked-word counter.
RESYNC_THR, 4, consecutive mismatches that force a reseed (0 disables reseeding).

Ports:
i_clk  input  1  clock
i_rst  input  1  reset, synchronous, active-high
i_start  input  1  arm the checker; pulse
i_vld  input  1  i_data is valid this cycle
i_data  input  NUM_BITS  received LFSR word
i_stop_code  input  NUM_BITS  word that ends the check
o_busy  output  1  high in SEED or CHECK
o_done  output  1  sticky; stop code was received
o_pass  output  1  o_done is high and error count is 0
o_err  output  1  one-cycle pulse on a mismatch
o_err_cnt  output  ERR_W  saturating mismatch count
o_word_cnt  output  CNT_W  saturating count of compared words
o_first_err_data  output  NUM_BITS  received word at the first mismatch
o_lockup  output  1  sticky; an all-ones word was received while in SEED

Behaviour:
- Reset: synchronous, active-high on i_clk. While i_rst is high, all state and outputs are cleared: FSM = IDLE, every output = 0, expected register = 0. Reset has priority over every other input, including mid-stream.
- Next-state function: next(x) = {x[NUM_BITS-1:1], x[49] XNOR x[40]}. Bits are numbered NUM_BITS..1. This function is shared with the generator.
- FSM states: IDLE, SEED, CHECK, DONE.
  - IDLE: i_start -> SEED.
  - SEED, on i_vld:
    - If i_data is all-ones: set o_lockup and stay in SEED. This is the XNOR lockup state.
    - Otherwise: expected <= next(i_data), clear the consecutive-mismatch count, -> CHECK.
    - The seed word is not compared and not counted.
    - If i_data == i_stop_code: -> DONE.
  - CHECK, on i_vld:
    - Compare i_data with expected; o_word_cnt += 1.
    - On mismatch: o_err pulses in the next cycle; o_err_cnt += 1; o_first_err_data is captured if o_err_cnt was 0; the consecutive-mismatch count increments.
    - On match: the consecutive-mismatch count clears.
    - expected <= next(expected) in either case; the checker does not resync to the received data.
    - If the consecutive-mismatch count reaches RESYNC_THR (nonzero): -> SEED, and the next valid word reseeds.
    - If i_data == i_stop_code: the word is compared first, then -> DONE. Stop has priority over resync.
  - DONE: o_done = 1; o_pass = (o_err_cnt == 0). i_start -> SEED. i_start also applies in SEED and CHECK.
- i_start clears o_done, o_pass, both counters, o_first_err_data, o_lockup and the consecutive-mismatch count, then enters SEED. If i_start and i_vld are high in the same cycle, start wins and the word is dropped.
- Cycles with i_vld low are ignored: no comparison and no advance of expected.
- Latency: all outputs are registered. A word at edge N shows its effect on o_err, the counters and o_done after edge N+1.
- Both counters saturate at all-ones and do not wrap.
- o_busy = state is SEED or CHECK.

Decomposition:
- Package lfsr_pkg holds:
  - tap constants LFSR_TAP_HI = 49 and LFSR_TAP_LO = 40;
  - function lfsr_next(x) for use by the generator and this checker;
  - the FSM state enum typedef.
- No sub-module is needed; the comparator and counters stay inline.

Test Plan:
1. Clean stream: i_start, then send 49'h1, 49'h3, 49'h7, 49'hF, with stop = 49'hF -> o_word_cnt = 3, o_err_cnt = 0, o_done = 1, o_pass = 1.
2. Single error: same stream with 49'h7 corrupted to 49'h5, stop = 49'hF -> o_err pulses once, o_err_cnt = 1, o_first_err_data = 49'h5, o_pass = 0.
3. Gapped valid: insert 3 idle cycles between 49'h3 and 49'h7 -> no errors, and expected does not advance during the gaps.
4. Resync: RESYNC_THR = 4, four garbage words, then a clean sequence from 49'h1 -> o_err_cnt = 4, FSM reseeds, later words match.
5. Lockup and saturation:
   - 49'h1_FFFF_FFFF_FFFF sent in SEED -> o_lockup = 1 and the FSM stays in SEED.
   - ERR_W = 4 with 20 mismatches and RESYNC_THR = 0 -> o_err_cnt = 15.
6. Reset mid-CHECK: assert i_rst for one cycle after 2 words -> all outputs are 0 on the next edge, state = IDLE, and further words are ignored until i_start.
